// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg
// Shared types and constants for the I2C register target:
//   - state_t      : protocol FSM states
//   - BITCNT_W     : width of the per-byte bit counter (counts 0..9)
//   - PTR_W        : register pointer width
//   - UNMAPPED_VAL : byte returned for indices outside the register map
//   - maj3()       : 3-input majority vote used by the optional line filter
package i2c_reg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam int         BITCNT_W     = 4;
  localparam int         PTR_W        = 8;
  localparam logic [7:0] UNMAPPED_VAL = 8'h00;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Brings the asynchronous SCL/SDA pad inputs into the clk domain and
// derives the bus events the protocol FSM works from.
//   clk, rst            : system clock, synchronous active-high reset
//   scl_i, sda_i        : raw pad inputs
//   sda_o               : conditioned SDA level (data sampling)
//   scl_rise_o/fall_o   : 1-clk pulses on conditioned SCL edges
//   start_o / stop_o    : 1-clk pulses on START / STOP conditions
// Build option I2C_GLITCH_FILTER_EN: adds a registered 3-sample majority
// filter after the 2-flop synchroniser (latency 2 -> 4 clk, 1-clk pulses
// rejected). Without it a 1-clk glitch is seen as a real edge.
module i2c_line_sync
  import i2c_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev_q, sda_prev_q;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  // A lone 1-clk sample never holds a majority of the 3-sample window.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_q  <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_flt_q  <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_lvl = scl_flt_q;
  assign sda_lvl = sda_flt_q;
`else
  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  assign sda_o      = sda_lvl;
  assign scl_rise_o = scl_lvl & ~scl_prev_q;
  assign scl_fall_o = ~scl_lvl & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
  assign start_o    = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
  assign stop_o     = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target
// I2C target with an 8-bit register pointer, auto-increment and writes.
// Register map: indices 0..NUM_RO-1 read-only (ro_data, snapshotted at the
// read address phase), NUM_RO..NUM_RO+NUM_RW-1 read/write (rw_data),
// everything else reads 8'h00 and silently discards writes.
//   clk, rst   : system clock, synchronous active-high reset
//   scl_in     : SCL pad input (async)
//   sda_in     : SDA pad input (async)
//   sda_oe     : 1 = pull SDA low (open drain)
//   ro_data    : read-only bytes, byte i at [8i+7:8i]
//   rw_data    : host-writable bytes, byte j at [8j+7:8j]
//   wr_stb     : 1-clk pulse per accepted RW byte write
//   wr_idx     : register index of that write
//   busy       : high from an addressed START until STOP
// Build option I2C_GLITCH_FILTER_EN enables the input glitch filter
// inside i2c_line_sync.
module i2c_reg_target
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h64,
  parameter int         NUM_RO   = 3,
  parameter int         NUM_RW   = 2,
  parameter logic [7:0] RW_RESET = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [NUM_RO*8-1:0] ro_data,
  output logic [NUM_RW*8-1:0] rw_data,
  output logic                wr_stb,
  output logic [PTR_W-1:0]    wr_idx,
  output logic                busy
);

  localparam int RW_N = (NUM_RW > 0) ? NUM_RW : 1;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_in),
    .sda_i     (sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  state_t              state_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  logic [6:0]          shreg_q;
  logic [6:0]          tx_q;      // remaining bits of the byte being read out
  logic [PTR_W-1:0]    ptr_q;
  logic                rnw_q;
  logic [7:0]          snap_q [NUM_RO];
  logic [7:0]          rw_q   [RW_N];
  logic                sda_oe_q, wr_stb_q, busy_q;
  logic [PTR_W-1:0]    wr_idx_q;

  logic [7:0] rx_byte;
  logic [7:0] rd_val;

  // Byte completed by the current SCL rise (only meaningful on the 8th).
  assign rx_byte = {shreg_q, sda_s};

  function automatic logic [7:0] read_value(input logic [PTR_W-1:0] p);
    logic [7:0] v;
    v = UNMAPPED_VAL;
    for (int i = 0; i < NUM_RO; i++)
      if (int'(p) == i) v = snap_q[i];
    for (int j = 0; j < NUM_RW; j++)
      if (int'(p) == NUM_RO + j) v = rw_q[j];
    return v;
  endfunction

  assign rd_val = read_value(ptr_q);

  // bitcnt_q counts SCL rises within a byte (8 after the last data bit).
  // In the ACK states 8 -> 9 marks "ACK slot driven / master ACK seen",
  // so the next SCL fall closes the ACK slot.
  always_ff @(posedge clk) begin
    wr_stb_q <= 1'b0;
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      ptr_q    <= '0;
      rnw_q    <= 1'b0;
      sda_oe_q <= 1'b0;
      wr_idx_q <= '0;
      busy_q   <= 1'b0;
      for (int j = 0; j < RW_N; j++) rw_q[j] <= RW_RESET;
    end else if (stop_det) begin
      state_q  <= IDLE;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (start_det) begin
      // Repeated START keeps ptr so a pointer write can precede a read.
      state_q  <= ADDR;
      bitcnt_q <= '0;
      sda_oe_q <= 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_q  <= rx_byte[6:0];
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == BITCNT_W'(7)) begin
              if (rx_byte[7:1] == I2C_ADDR) begin
                state_q <= ADDR_ACK;
                busy_q  <= 1'b1;
                rnw_q   <= rx_byte[0];
                if (rx_byte[0])
                  for (int i = 0; i < NUM_RO; i++) snap_q[i] <= ro_data[8*i +: 8];
              end else begin
                state_q <= IGNORE;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bitcnt_q == BITCNT_W'(8)) begin
              sda_oe_q <= 1'b1;
              bitcnt_q <= BITCNT_W'(9);
            end else begin
              bitcnt_q <= '0;
              if (state_q == ADDR_ACK && rnw_q) begin
                // First read bit goes out on the same fall that ends the ACK.
                state_q  <= RDATA;
                sda_oe_q <= ~rd_val[7];
                tx_q     <= rd_val[6:0];
              end else begin
                state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
                sda_oe_q <= 1'b0;
              end
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shreg_q  <= rx_byte[6:0];
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == BITCNT_W'(7)) begin
              ptr_q   <= rx_byte;
              state_q <= PTR_ACK;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shreg_q  <= rx_byte[6:0];
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == BITCNT_W'(7)) begin
              for (int j = 0; j < NUM_RW; j++) begin
                if (int'(ptr_q) == NUM_RO + j) begin
                  rw_q[j]  <= rx_byte;
                  wr_stb_q <= 1'b1;
                  wr_idx_q <= ptr_q;
                end
              end
              ptr_q   <= ptr_q + 1'b1;
              state_q <= WDATA_ACK;
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bitcnt_q <= bitcnt_q + 1'b1;
          end else if (scl_fall && bitcnt_q != '0) begin
            if (bitcnt_q == BITCNT_W'(8)) begin
              sda_oe_q <= 1'b0;
              state_q  <= RD_ACK;
            end else begin
              sda_oe_q <= ~tx_q[6];
              tx_q     <= {tx_q[5:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_q <= IGNORE;
            end else begin
              ptr_q    <= ptr_q + 1'b1;
              bitcnt_q <= BITCNT_W'(9);
            end
          end else if (scl_fall && bitcnt_q == BITCNT_W'(9)) begin
            bitcnt_q <= '0;
            state_q  <= RDATA;
            sda_oe_q <= ~rd_val[7];
            tx_q     <= rd_val[6:0];
          end
        end

        IDLE, IGNORE: ;

        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < NUM_RW; j++) begin : g_rw_out
    assign rw_data[8*j +: 8] = rw_q[j];
  end

  assign sda_oe = sda_oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule
